// File: rtl/axby_pkg.sv
// Shared types and widths for the A*X + B*Y shift-add datapath.
// Imported by the datapath and by anything that inspects its state.
package axby_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = 16;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/axby_datapath.sv
// Serial shift-add unit computing RES = A_COEF*X + B_COEF*Y.
// One operand bit pair per cycle, eight cycles per result.
module axby_datapath
  import axby_pkg::*;
#(
  parameter logic [6:0] A_COEF = 7'd3,
  parameter logic [6:0] B_COEF = 7'd5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] DIN,
  input  logic              PLx,
  input  logic              PLy,
  input  logic              START,
  input  logic              OEH,
  input  logic              OEL,
  output logic              SETRDYP,
  output logic [DATA_W-1:0] DOUT,
  output logic              BUSY
);

  state_t             state;
  logic [DATA_W-1:0]  x_q;
  logic [DATA_W-1:0]  y_q;
  logic [RES_W-1:0]   acc;
  logic [RES_W-1:0]   res;
  logic [CNT_W-1:0]   cnt;

  logic [RES_W-1:0]   a_term;
  logic [RES_W-1:0]   b_term;
  logic [RES_W-1:0]   acc_nxt;

  // Partial products for the current bit position, summed into ACC.
  always_comb begin
    a_term  = '0;
    b_term  = '0;
    if (x_q[cnt])
      a_term = {9'd0, A_COEF} << cnt;
    if (y_q[cnt])
      b_term = {9'd0, B_COEF} << cnt;
    acc_nxt = acc + a_term + b_term;
  end

  // Control FSM with operand, accumulator and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      x_q   <= '0;
      y_q   <= '0;
      acc   <= '0;
      res   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (PLx)
            x_q <= DIN;
          if (PLy)
            y_q <= DIN;
          if (START) begin
            state <= MUL;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        MUL: begin
          if (!START) begin
            state <= IDLE;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == {CNT_W{1'b1}}) begin
              res   <= acc_nxt;
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (!START)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status flags from registered state; result bytes muxed onto DOUT.
  always_comb begin
    SETRDYP = (state == DONE);
    BUSY    = (state == MUL);
    DOUT    = '0;
    if (OEH)
      DOUT = res[15:8];
    else if (OEL)
      DOUT = res[7:0];
  end

endmodule

// File: tb/tb_axby_datapath.sv
// Directed bench for axby_datapath: default and 127/127 coefficients.
// Inputs change 1ns after a rising edge; outputs checked there too.
module tb_axby_datapath;

  logic       clk;
  logic       reset_n;
  logic [7:0] DIN;
  logic       PLx, PLy, START, OEH, OEL;
  logic       rdy0, busy0, rdy1, busy1;
  logic [7:0] dout0, dout1;

  int total = 0;
  int bad   = 0;

  axby_datapath u0 (
    .clk(clk), .reset_n(reset_n), .DIN(DIN),
    .PLx(PLx), .PLy(PLy), .START(START),
    .OEH(OEH), .OEL(OEL),
    .SETRDYP(rdy0), .DOUT(dout0), .BUSY(busy0)
  );

  axby_datapath #(.A_COEF(7'd127), .B_COEF(7'd127)) u1 (
    .clk(clk), .reset_n(reset_n), .DIN(DIN),
    .PLx(PLx), .PLy(PLy), .START(START),
    .OEH(OEH), .OEL(OEL),
    .SETRDYP(rdy1), .DOUT(dout1), .BUSY(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag,
                    input logic [7:0] hi,
                    input logic [7:0] lo);
    OEH = 1'b1; OEL = 1'b0; #1;
    chk({tag, "_hi"}, {8'd0, dout0}, {8'd0, hi});
    OEH = 1'b0; OEL = 1'b1; #1;
    chk({tag, "_lo"}, {8'd0, dout0}, {8'd0, lo});
    OEH = 1'b0; OEL = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    DIN = '0; PLx = 0; PLy = 0; START = 0;
    OEH = 1'b1; OEL = 1'b1;
    #3;
    chk("rst_rdy", {15'd0, rdy0}, 16'd0);
    chk("rst_busy", {15'd0, busy0}, 16'd0);
    chk("rst_dout", {8'd0, dout0}, 16'd0);
    OEH = 0; OEL = 0;
    step();
    step();
    reset_n = 1'b1;
    step();

    // 3*10 + 5*20 = 130; Y loaded in the START cycle
    PLx = 1; DIN = 8'd10;
    step();
    PLx = 0; PLy = 1; DIN = 8'd20; START = 1;
    step();
    PLy = 0; DIN = 8'd0;
    chk("t1_busy0", {15'd0, busy0}, 16'd1);
    for (int i = 0; i < 7; i++) begin
      if (i == 1) begin PLx = 1; DIN = 8'd99; end
      else begin PLx = 0; DIN = 8'd0; end
      step();
      chk("t1_rdy_lo", {15'd0, rdy0}, 16'd0);
    end
    PLx = 0;
    step();
    chk("t1_rdy", {15'd0, rdy0}, 16'd1);
    chk("t1_busy", {15'd0, busy0}, 16'd0);
    rd("t1", 8'h00, 8'h82);
    OEH = 1; OEL = 1; #1;
    chk("t1_both", {8'd0, dout0}, 16'h0000);
    OEH = 0; OEL = 0;
    step();
    step();
    chk("t1_hold", {15'd0, rdy0}, 16'd1);
    START = 0;
    step();
    chk("t1_idle", {15'd0, rdy0}, 16'd0);
    chk("t1_idleb", {15'd0, busy0}, 16'd0);

    // X=Y=255: u1 -> 64770 = FD02, u0 -> 2040 = 07F8
    PLx = 1; PLy = 1; DIN = 8'd255; START = 1;
    step();
    PLx = 0; PLy = 0; DIN = 8'd0;
    repeat (8) step();
    chk("t2_rdy1", {15'd0, rdy1}, 16'd1);
    OEH = 1; OEL = 0; #1;
    chk("t2_hi", {8'd0, dout1}, 16'h00FD);
    OEH = 0; OEL = 1; #1;
    chk("t2_lo", {8'd0, dout1}, 16'h0002);
    OEH = 1; OEL = 1; #1;
    chk("t2_both", {8'd0, dout1}, 16'h00FD);
    OEH = 0; OEL = 0;
    rd("t2_u0", 8'h07, 8'hF8);
    START = 0;
    step();

    // abort after 4 MUL edges; RES stays 07F8
    PLx = 1; PLy = 1; DIN = 8'd1; START = 1;
    step();
    PLx = 0; PLy = 0;
    repeat (4) begin
      step();
      chk("t3_busy", {15'd0, busy0}, 16'd1);
    end
    START = 0;
    step();
    chk("t3_busy_fall", {15'd0, busy0}, 16'd0);
    chk("t3_rdy", {15'd0, rdy0}, 16'd0);
    rd("t3", 8'h07, 8'hF8);
    repeat (9) step();
    chk("t3_rdy_late", {15'd0, rdy0}, 16'd0);

    // reset mid-MUL, then 3*6 + 5*7 = 53
    START = 1;
    step();
    repeat (3) step();
    reset_n = 0;
    #1;
    OEL = 1; #1;
    chk("t4_dout", {8'd0, dout0}, 16'd0);
    chk("t4_rdy", {15'd0, rdy0}, 16'd0);
    chk("t4_busy", {15'd0, busy0}, 16'd0);
    OEL = 0;
    START = 0;
    #1 reset_n = 1;
    step();
    chk("t4_idle", {15'd0, busy0}, 16'd0);
    PLx = 1; DIN = 8'd6;
    step();
    PLx = 0; PLy = 1; DIN = 8'd7; START = 1;
    step();
    PLy = 0;
    repeat (8) step();
    chk("t4_rdy2", {15'd0, rdy0}, 16'd1);
    rd("t4", 8'h00, 8'h35);
    START = 0;
    step();

    // X=Y=0, START held 20 cycles
    PLx = 1; PLy = 1; DIN = 8'd0; START = 1;
    step();
    PLx = 0; PLy = 0;
    repeat (7) step();
    chk("t5_rdy_pre", {15'd0, rdy0}, 16'd0);
    step();
    chk("t5_rdy_n8", {15'd0, rdy0}, 16'd1);
    repeat (11) step();
    chk("t5_rdy_hold", {15'd0, rdy0}, 16'd1);
    rd("t5", 8'h00, 8'h00);
    START = 0;
    step();
    chk("t5_idle", {15'd0, rdy0}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
